// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolution unit.
package bru_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } bru_state_e;

  localparam int unsigned PC_STEP = 4;

  // Conditional-branch funct3 encodings; 3'b010 and 3'b011 are undefined.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/bru_ctrl_blu.sv
// Branch logic unit: evaluates a conditional-branch compare selected by funct3.
module blu
  import bru_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken
);

  // Undefined encodings resolve as not taken.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bru_ctrl.sv
// Branch resolution controller: resolves control transfers in EX, redirects fetch on
// mispredictions, pulses predictor updates and keeps performance counters.
module bru_ctrl
  import bru_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic [XLEN-1:0]  ex_link,
  input  logic             trap_flush,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  input  logic             redir_ready,
  output logic             flush,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic [XLEN-1:0]  upd_target,
  output logic             upd_taken,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispred
);

  bru_state_e      state;
  logic            blu_taken;
  logic            actual_taken;
  logic [XLEN-1:0] actual_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] next_pc;
  logic            mispred;
  logic            accept;

  blu #(.XLEN(XLEN)) u_blu (
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .funct3 (ex_funct3),
    .taken  (blu_taken)
  );

  assign ex_link     = ex_pc + XLEN'(PC_STEP);
  assign jalr_sum    = ex_rs1 + ex_imm;
  assign ex_ready    = (state == IDLE);
  assign redir_valid = (state == REDIR);
  assign accept      = ex_valid & ex_ready & ~trap_flush;

  // Outcome, target and misprediction for the instruction currently in EX.
  always_comb begin
    actual_taken  = 1'b0;
    actual_target = ex_pc + ex_imm;
    if (ex_is_jal || ex_is_jalr) begin
      actual_taken = 1'b1;
    end else begin
      actual_taken = blu_taken;
    end
    if (ex_is_jalr) begin
      actual_target = {jalr_sum[XLEN-1:1], 1'b0};
    end else begin
      actual_target = ex_pc + ex_imm;
    end
    next_pc = actual_taken ? actual_target : ex_link;
    mispred = (actual_taken != ex_pred_taken) ||
              (actual_taken && (actual_target != ex_pred_target));
  end

  // Redirect FSM, one-cycle flush/update pulses, update payload and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      redir_pc    <= '0;
      flush       <= 1'b0;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_target  <= '0;
      upd_taken   <= 1'b0;
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else begin
      flush     <= 1'b0;
      upd_valid <= 1'b0;
      if (trap_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              upd_valid  <= 1'b1;
              upd_pc     <= ex_pc;
              upd_target <= actual_target;
              upd_taken  <= actual_taken;
              cnt_branch <= cnt_branch + CNT_W'(1);
              if (mispred) begin
                state       <= REDIR;
                redir_pc    <= next_pc;
                flush       <= 1'b1;
                cnt_mispred <= cnt_mispred + CNT_W'(1);
              end
            end
          end
          REDIR: begin
            if (redir_ready) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bru_ctrl.sv
// Directed self-checking bench for bru_ctrl.
module tb_bru_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_target, ex_link;
  logic             ex_pred_taken;
  logic             trap_flush;
  logic             redir_valid;
  logic [XLEN-1:0]  redir_pc;
  logic             redir_ready;
  logic             flush;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc, upd_target;
  logic             upd_taken;
  logic [CNT_W-1:0] cnt_branch, cnt_mispred;

  int n_cmp = 0;
  int n_err = 0;

  bru_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_link(ex_link), .trap_flush(trap_flush),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
    .flush(flush), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [63:0] pc, input logic [63:0] imm,
                       input logic pt, input logic [63:0] ptgt);
    ex_valid       = 1'b1;
    ex_is_jal      = jal;
    ex_is_jalr     = jalr;
    ex_funct3      = f3;
    ex_rs1         = rs1;
    ex_rs2         = rs2;
    ex_pc          = pc;
    ex_imm         = imm;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0; ex_funct3 = 3'b000;
    ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0; ex_pred_taken = 1'b0;
    ex_pred_target = '0; trap_flush = 1'b0; redir_ready = 1'b0;
    #12;
    check("rst_redir_valid", redir_valid, 64'd0);
    check("rst_flush", flush, 64'd0);
    check("rst_upd_valid", upd_valid, 64'd0);
    check("rst_cnt_branch", cnt_branch, 64'd0);
    check("rst_redir_pc", redir_pc, 64'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("rst_ex_ready", ex_ready, 64'd1);

    // BEQ correctly predicted taken
    drive(1'b0, 1'b0, 3'b000, 64'd5, 64'd5, 64'h1000, 64'h40, 1'b1, 64'h1040);
    #1 check("beq_link", ex_link, 64'h1004);
    tick(); ex_valid = 1'b0;
    check("beq_flush", flush, 64'd0);
    check("beq_redir", redir_valid, 64'd0);
    check("beq_upd_valid", upd_valid, 64'd1);
    check("beq_upd_taken", upd_taken, 64'd1);
    check("beq_upd_target", upd_target, 64'h1040);
    check("beq_upd_pc", upd_pc, 64'h1000);
    check("beq_cnt_branch", cnt_branch, 64'd1);
    check("beq_cnt_mispred", cnt_mispred, 64'd0);
    tick();
    check("beq_upd_pulse", upd_valid, 64'd0);

    // BLT taken but predicted not taken; held redirect
    drive(1'b0, 1'b0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h2000,
          64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0);
    tick(); ex_valid = 1'b0;
    check("blt_flush", flush, 64'd1);
    check("blt_redir_valid", redir_valid, 64'd1);
    check("blt_redir_pc", redir_pc, 64'h1FF8);
    check("blt_ex_ready", ex_ready, 64'd0);
    check("blt_upd_taken", upd_taken, 64'd1);
    check("blt_cnt_mispred", cnt_mispred, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("blt_hold_flush", flush, 64'd0);
      check("blt_hold_valid", redir_valid, 64'd1);
      check("blt_hold_pc", redir_pc, 64'h1FF8);
    end
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;
    check("blt_release", redir_valid, 64'd0);
    check("blt_ready_back", ex_ready, 64'd1);

    // BGEU not taken, predicted taken; minimum one-cycle occupancy
    drive(1'b0, 1'b0, 3'b111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3000, 64'h100, 1'b1, 64'h3100);
    tick(); ex_valid = 1'b0;
    check("bgeu_redir_pc", redir_pc, 64'h3004);
    check("bgeu_upd_taken", upd_taken, 64'd0);
    check("bgeu_upd_target", upd_target, 64'h3100);
    check("bgeu_cnt_branch", cnt_branch, 64'd3);
    check("bgeu_cnt_mispred", cnt_mispred, 64'd2);
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;
    check("bgeu_min_occ", redir_valid, 64'd0);

    // JALR with low bit cleared, predicted correctly
    drive(1'b0, 1'b1, 3'b000, 64'h3001, 64'd0, 64'h4000, 64'd2, 1'b1, 64'h3002);
    #1 check("jalr_link", ex_link, 64'h4004);
    tick(); ex_valid = 1'b0;
    check("jalr_flush", flush, 64'd0);
    check("jalr_upd_target", upd_target, 64'h3002);
    check("jalr_cnt_mispred", cnt_mispred, 64'd2);

    // Undefined funct3 resolves not taken
    drive(1'b0, 1'b0, 3'b010, 64'd7, 64'd7, 64'h4100, 64'h8, 1'b0, 64'h0);
    tick(); ex_valid = 1'b0;
    check("undef_upd_taken", upd_taken, 64'd0);
    check("undef_flush", flush, 64'd0);

    // JAL taken as predicted but wrong target
    drive(1'b1, 1'b0, 3'b000, 64'd0, 64'd0, 64'h6000, 64'h20, 1'b1, 64'h6040);
    tick(); ex_valid = 1'b0;
    check("jal_redir_pc", redir_pc, 64'h6020);
    check("jal_flush", flush, 64'd1);
    check("jal_cnt_mispred", cnt_mispred, 64'd3);
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;

    // Mispredict then trap_flush while redirect pending
    drive(1'b0, 1'b0, 3'b001, 64'd1, 64'd2, 64'h5000, 64'h10, 1'b0, 64'h0);
    tick(); ex_valid = 1'b0;
    check("bne_redir_pc", redir_pc, 64'h5010);
    check("bne_cnt_branch", cnt_branch, 64'd7);
    trap_flush = 1'b1;
    tick();
    check("trap_redir_drop", redir_valid, 64'd0);
    check("trap_idle", ex_ready, 64'd1);
    // Accept attempt during trap_flush is suppressed
    drive(1'b0, 1'b0, 3'b000, 64'd1, 64'd2, 64'h5100, 64'h10, 1'b1, 64'h5110);
    tick(); ex_valid = 1'b0; trap_flush = 1'b0;
    check("trap_no_upd", upd_valid, 64'd0);
    check("trap_no_flush", flush, 64'd0);
    check("trap_no_redir", redir_valid, 64'd0);
    check("trap_cnt_branch", cnt_branch, 64'd7);
    check("trap_cnt_mispred", cnt_mispred, 64'd4);

    // Eight back-to-back correct predictions
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'b000, 64'd3, 64'd3, 64'h8000 + 64'(i * 16), 64'h100, 1'b1,
            64'h8100 + 64'(i * 16));
      tick();
      check("b2b_upd_valid", upd_valid, 64'd1);
      check("b2b_upd_pc", upd_pc, 64'h8000 + 64'(i * 16));
      check("b2b_ready", ex_ready, 64'd1);
    end
    ex_valid = 1'b0;
    check("b2b_cnt_branch", cnt_branch, 64'd15);
    check("b2b_cnt_mispred", cnt_mispred, 64'd4);

    // Async reset mid-REDIR
    drive(1'b0, 1'b0, 3'b000, 64'd1, 64'd2, 64'h9000, 64'h40, 1'b1, 64'h9040);
    tick(); ex_valid = 1'b0;
    check("pre_rst_redir", redir_valid, 64'd1);
    check("pre_rst_pc", redir_pc, 64'h9004);
    #2 rst = 1'b1;
    #1;
    check("arst_redir_valid", redir_valid, 64'd0);
    check("arst_redir_pc", redir_pc, 64'd0);
    check("arst_flush", flush, 64'd0);
    check("arst_upd_valid", upd_valid, 64'd0);
    check("arst_upd_target", upd_target, 64'd0);
    check("arst_cnt_branch", cnt_branch, 64'd0);
    check("arst_cnt_mispred", cnt_mispred, 64'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("arst_ready", ex_ready, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
